frame_feeder: RTL and testbench

FRAME_FEEDER -- requirements
Module: frame_feeder

---
 rtl/frame_feeder.sv | 121 ++++++++++++
 tb/tb_frame_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_feeder.sv
// Double-buffered sample framer feeding a frame-consuming core.
// One bank fills from the sensor while the other is held for the core.
module frame_feeder #(
  parameter int FRAME_LEN = 40,
  parameter int TIMEOUT   = 1023
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic signed [15:0] i_sample,
  input  logic               i_sof,
  output logic               o_ready,
  output logic               o_next,
  output logic signed [15:0] o_data [0:FRAME_LEN-1],
  input  logic               i_core_next,
  input  logic               i_core_finished,
  output logic               o_overflow,
  output logic [7:0]         o_frame_count
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  localparam logic [9:0] TMAX = 10'(TIMEOUT - 1);

  typedef enum logic {S_ISSUE, S_WAIT} state_t;

  state_t state, state_nxt;

  logic signed [15:0] mem0 [FRAME_LEN];
  logic signed [15:0] mem1 [FRAME_LEN];

  logic [1:0]    full, full_nxt;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] wr_addr;
  logic [9:0]    cnt;
  logic          accept;
  logic          fill_done;
  logic          rel;

  assign o_ready   = !full[wr_bank];
  assign accept    = i_valid && o_ready;
  assign wr_addr   = i_sof ? '0 : wr_idx;
  assign fill_done = accept && (wr_addr == LAST);

  // Bank storage carries no reset; stale data is never issued.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      if (wr_bank) mem1[wr_addr] <= i_sample;
      else         mem0[wr_addr] <= i_sample;
    end
  end

  always_comb begin
    for (int k = 0; k < FRAME_LEN; k++) begin
      o_data[k] = rd_bank ? mem1[k] : mem0[k];
    end
  end

  always_comb begin
    state_nxt = state;
    o_next    = 1'b0;
    rel       = 1'b0;
    unique case (state)
      S_ISSUE: begin
        if (full[rd_bank]) begin
          o_next    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_core_next || i_core_finished || cnt == TMAX) begin
          rel       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  // Fill and release always touch different banks, so both apply.
  always_comb begin
    full_nxt = full;
    if (rel)       full_nxt[rd_bank] = 1'b0;
    if (fill_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_ISSUE;
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      cnt           <= '0;
      o_overflow    <= 1'b0;
      o_frame_count <= '0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      if (accept) begin
        if (fill_done) begin
          wr_idx  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_idx <= wr_addr + 1'b1;
        end
      end
      if (i_valid && !o_ready) o_overflow <= 1'b1;
      if (rel) rd_bank <= !rd_bank;
      if (o_next) begin
        cnt           <= '0;
        o_frame_count <= o_frame_count + 8'd1;
      end else if (state == S_WAIT && !rel) begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_feeder.sv
// Directed bench for frame_feeder with a frame scoreboard
// checked on every o_next pulse.
module tb_frame_feeder;

  localparam int FL = 40;
  localparam int TO = 1023;

  logic               clk;
  logic               rst_n;
  logic               valid;
  logic signed [15:0] sample;
  logic               sof;
  logic               ready;
  logic               nxt;
  logic signed [15:0] data [0:FL-1];
  logic               core_next;
  logic               core_fin;
  logic               ovf;
  logic [7:0]         fcount;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nexts  = 0;
  int prev_at = 0;
  int last_at = 0;
  int base   = 0;
  int sb [$];

  frame_feeder #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid),
    .i_sample       (sample),
    .i_sof          (sof),
    .o_ready        (ready),
    .o_next         (nxt),
    .o_data         (data),
    .i_core_next    (core_next),
    .i_core_finished(core_fin),
    .o_overflow     (ovf),
    .o_frame_count  (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issued frame must match the next queued frame.
  always @(negedge clk) begin
    if (rst_n && nxt) begin
      nexts++;
      prev_at = last_at;
      last_at = cyc;
      if (sb.size() < FL) begin
        check("sb_underflow", sb.size(), FL);
      end else begin
        for (int k = 0; k < FL; k++) begin
          int e;
          e = sb.pop_front();
          check("frame_data", data[k], e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit s, input bit fin);
    valid    = 1'b1;
    sample   = 16'(v);
    sof      = s;
    core_fin = fin;
    step();
    valid    = 1'b0;
    sof      = 1'b0;
    core_fin = 1'b0;
  endtask

  task automatic ack();
    core_next = 1'b1;
    step();
    core_next = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    valid = 1'b0;
    sof   = 1'b0;
    core_next = 1'b0;
    core_fin  = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    base = nexts;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    valid = 1'b0;
    sample = '0;
    sof = 1'b0;
    core_next = 1'b0;
    core_fin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_next", nxt, 0);
    check("rst_count", fcount, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();

    // Basic frame, ack during the o_next cycle is ignored
    for (int k = 0; k < FL; k++) begin
      sb.push_back(k);
      send(k, k == 0, 0);
    end
    check("t1_next", nxt, 1);
    ack();
    check("t1_count", fcount, 1);
    for (int k = 0; k < FL; k++) begin
      sb.push_back(50 + k);
      send(50 + k, 0, 0);
    end
    repeat (3) step();
    check("t1_hold", nexts, 1);
    ack();
    check("t1_next2", nxt, 1);
    step();
    check("t1_count2", fcount, 2);
    ack();

    // Two frames queued, overflow on the 81st sample
    reset_dut();
    for (int k = 0; k < 2 * FL; k++) begin
      sb.push_back(k);
      send(k, k == 0, 0);
    end
    check("t2_ovf0", ovf, 0);
    check("t2_ready", ready, 0);
    send(999, 0, 0);
    check("t2_ovf", ovf, 1);
    check("t2_ready2", ready, 0);
    check("t2_one", nexts - base, 1);
    ack();
    check("t2_next", nxt, 1);
    step();
    check("t2_count", fcount, 2);
    ack();

    // Partial frame restarted by sof
    reset_dut();
    for (int k = 0; k < 17; k++) send(500 + k, k == 0, 0);
    sb.push_back(100);
    send(100, 1, 0);
    for (int k = 1; k < FL; k++) begin
      sb.push_back(100 + k);
      send(100 + k, 0, 0);
    end
    check("t3_next", nxt, 1);
    step();
    check("t3_one", nexts - base, 1);
    ack();

    // Timeout release and back-to-back issue
    reset_dut();
    for (int k = 0; k < FL; k++) begin
      sb.push_back(200 + k);
      send(200 + k, k == 0, 0);
    end
    for (int k = 0; k < FL; k++) begin
      sb.push_back(300 + k);
      send(300 + k, 0, 0);
    end
    n = 0;
    while (nexts - base < 2 && n < 1200) begin
      step();
      n++;
    end
    check("t4_issued", nexts - base, 2);
    check("t4_gap", last_at - prev_at, TO + 1);

    // Async reset in WAIT with both banks full
    for (int k = 0; k < FL; k++) send(400 + k, 0, 0);
    check("t5_ready_pre", ready, 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_next", nxt, 0);
    check("t5_ready", ready, 1);
    check("t5_count", fcount, 0);
    #1;
    rst_n = 1'b1;
    step();
    base = nexts;
    repeat (20) step();
    check("t5_quiet", nexts - base, 0);
    for (int k = 0; k < FL; k++) begin
      sb.push_back(600 + k);
      send(600 + k, k == 0, 0);
    end
    check("t5_next2", nxt, 1);
    step();

    // Finish-release coinciding with fill of the other bank
    for (int k = 0; k < FL - 1; k++) begin
      sb.push_back(700 + k);
      send(700 + k, 0, 0);
    end
    sb.push_back(739);
    send(739, 0, 1);
    check("t6_next", nxt, 1);
    check("t6_ovf", ovf, 0);
    check("t6_count", fcount, 1);
    step();
    check("t6_count2", fcount, 2);
    check("t6_issued", nexts - base, 2);
    ack();
    check("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
